// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer port arbiter: capture-mode state
// encoding and default geometry of the 640x480 RGB444 frame RAM.
package fb_pkg;

  localparam int unsigned DEF_ADDR_W       = 19;
  localparam int unsigned DEF_DATA_W       = 12;
  localparam int unsigned DEF_FIFO_DEPTH   = 4;
  localparam int unsigned DEF_FRAME_PIXELS = 307200;

  // Capture-mode sequencer states
  typedef enum logic [1:0] {
    LIVE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    FROZEN  = 2'd3
  } fb_state_e;

endpackage

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO buffering camera pixel writes ahead of the frame RAM.
// Ports:
//   clk, rst            clock, asynchronous active-low reset (empties FIFO)
//   push, push_data     write an entry (caller guarantees !full_c or pop)
//   pop                 drop the head entry (caller guarantees !empty_c)
//   head_c              current head entry
//   full_c, empty_c     status, derived from the wrap-bit pointers
module fb_wr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 31
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_c,
  output logic         full_c,
  output logic         empty_c
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [W-1:0]     mem [DEPTH];

  // Pointer update; the extra MSB distinguishes full from empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage; a push into a full FIFO overwrites the slot being popped this cycle
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[IDX_W-1:0]] <= push_data;
  end

  assign head_c  = mem[rd_ptr[IDX_W-1:0]];
  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                   (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);

endmodule

// File: rtl/fb_port_arbiter.sv
// Frame RAM port arbiter: shares the single-port frame RAM between the camera
// pixel writer (buffered through fb_wr_fifo) and the display reader (always
// granted), and sequences live / snapshot capture modes.
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   cam_vsync/cam_wr_en/addr/data     camera pixel stream
//   snap_req, live_req                capture-mode request pulses
//   rd_req, rd_addr -> rd_data, rd_valid  display read path (2-cycle latency)
//   ram_en/we/addr/wdata, ram_rdata   frame RAM port (sync read, 1-cycle)
//   frozen, frame_done, ovf_cnt       status
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int unsigned FRAME_PIXELS = DEF_FRAME_PIXELS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cam_vsync,
  input  logic              cam_wr_en,
  input  logic [ADDR_W-1:0] cam_addr,
  input  logic [DATA_W-1:0] cam_data,
  input  logic              snap_req,
  input  logic              live_req,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              frozen,
  output logic              frame_done,
  output logic [7:0]        ovf_cnt
);

  localparam int unsigned ENT_W = ADDR_W + DATA_W;

  fb_state_e          state;
  fb_state_e          state_nxt;
  logic               frame_done_nxt;
  logic               vsync_q;
  logic               frame_start;
  logic               frame_end;
  logic               push_cand;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic               wr_drop;
  logic [ENT_W-1:0]   fifo_head;

  assign frame_start = cam_vsync & ~vsync_q;
  assign frame_end   = ~cam_vsync & vsync_q;

  // Reads always win the port; the FIFO drains only on read-free cycles
  assign fifo_pop  = ~rd_req & ~fifo_empty;
  assign push_cand = cam_wr_en && (state != FROZEN) &&
                     (cam_addr < ADDR_W'(FRAME_PIXELS));
  assign fifo_push = push_cand & (~fifo_full | fifo_pop);
  assign wr_drop   = push_cand & fifo_full & ~fifo_pop;

  // Read data comes straight from the RAM; only its valid flag is pipelined
  assign rd_data = ram_rdata;

  fb_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENT_W)
  ) u_wr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({cam_addr, cam_data}),
    .pop       (fifo_pop),
    .head_c    (fifo_head),
    .full_c    (fifo_full),
    .empty_c   (fifo_empty)
  );

  // Capture-mode state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LIVE;
    else      state <= state_nxt;
  end

  // Next-state logic; live_req overrides everything else
  always_comb begin
    state_nxt      = state;
    frame_done_nxt = 1'b0;
    case (state)
      LIVE: begin
        if (!live_req && snap_req) state_nxt = ARM;
      end
      ARM: begin
        if (live_req)         state_nxt = LIVE;
        else if (frame_start) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (live_req) begin
          state_nxt = LIVE;
        end else if (frame_end) begin
          state_nxt      = FROZEN;
          frame_done_nxt = 1'b1;
        end
      end
      FROZEN: begin
        if (live_req)      state_nxt = LIVE;
        else if (snap_req) state_nxt = ARM;
      end
      default: state_nxt = LIVE;
    endcase
  end

  // Registered outputs: RAM port, read valid, status and overflow counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsync_q    <= 1'b0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      rd_valid   <= 1'b0;
      frozen     <= 1'b0;
      frame_done <= 1'b0;
      ovf_cnt    <= '0;
    end else begin
      vsync_q    <= cam_vsync;
      frozen     <= (state_nxt == FROZEN);
      frame_done <= frame_done_nxt;
      // RAM returns read data one cycle after a read is issued
      rd_valid   <= ram_en & ~ram_we;
      if (wr_drop && (ovf_cnt != 8'hFF)) ovf_cnt <= ovf_cnt + 8'd1;
      if (rd_req) begin
        ram_en   <= 1'b1;
        ram_we   <= 1'b0;
        ram_addr <= rd_addr;
      end else if (fifo_pop) begin
        ram_en    <= 1'b1;
        ram_we    <= 1'b1;
        ram_addr  <= fifo_head[ENT_W-1:DATA_W];
        ram_wdata <= fifo_head[DATA_W-1:0];
      end else begin
        ram_en <= 1'b0;
        ram_we <= 1'b0;
      end
    end
  end

endmodule
